// File: rtl/fproc_meas_pkg.sv
// fproc_meas_pkg: shared types and width helpers for the measurement
// fan-out block (per-core FSM states, request modes, flag positions).
package fproc_meas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      LAST  = 1'b0,
      FRESH = 1'b1
   } mode_t;

   // Channel index width; a single channel still needs one id bit.
   function automatic int ch_w(input int n_meas);
      return (n_meas > 1) ? $clog2(n_meas) : 1;
   endfunction

   // Request id = {mode, channel}.
   function automatic int id_w(input int n_meas);
      return ch_w(n_meas) + 1;
   endfunction

   // Response data = {err, tmo, value}.
   function automatic int data_w(input int meas_w);
      return meas_w + 2;
   endfunction

   // Flag positions, relative to the response width.
   function automatic int err_bit(input int dw);
      return dw - 1;
   endfunction

   function automatic int tmo_bit(input int dw);
      return dw - 2;
   endfunction

endpackage

// File: rtl/fproc_iface.sv
// fproc_iface: one core's request/response channel.
//   enable : core request strobe (into the block)
//   id     : {mode, channel} of the request (into the block)
//   ready  : one-cycle response strobe (out of the block)
//   data   : {err, tmo, value}, held between responses (out of the block)
interface fproc_iface import fproc_meas_pkg::*; #(
   parameter int N_MEAS = 5,
   parameter int MEAS_W = 1
) ();
   localparam int ID_W   = id_w(N_MEAS);
   localparam int DATA_W = data_w(MEAS_W);

   logic              enable;
   logic [ID_W-1:0]   id;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport fproc (input enable, input id, output ready, output data);
endinterface

// File: rtl/fproc_meas_port.sv
// fproc_meas_port: per-core request FSM.
//   clk, reset     : clock, async active-low reset
//   enable, id     : request strobe and {mode, channel}
//   store          : shared last-value store, one entry per channel
//   meas           : live measurement values (what the store takes next edge)
//   meas_valid     : per-channel strobes
//   cfg_timeout    : FRESH wait limit, 0 = forever
//   ready, data    : registered response pulse and held response word
module fproc_meas_port import fproc_meas_pkg::*; #(
   parameter int N_MEAS    = 5,
   parameter int MEAS_W    = 1,
   parameter int TIMEOUT_W = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [id_w(N_MEAS)-1:0]        id,
   input  logic [N_MEAS-1:0][MEAS_W-1:0]  store,
   input  logic [N_MEAS-1:0][MEAS_W-1:0]  meas,
   input  logic [N_MEAS-1:0]              meas_valid,
   input  logic [TIMEOUT_W-1:0]           cfg_timeout,
   output logic                           ready,
   output logic [data_w(MEAS_W)-1:0]      data
);
   localparam int CH_W    = ch_w(N_MEAS);
   localparam int ID_W    = id_w(N_MEAS);
   localparam int DATA_W  = data_w(MEAS_W);
   localparam int ERR_BIT = err_bit(DATA_W);
   localparam int TMO_BIT = tmo_bit(DATA_W);

   state_t                state, state_nxt;
   mode_t                 mode;
   logic [CH_W-1:0]       ch;
   logic [TIMEOUT_W-1:0]  cnt, cnt_nxt;
   logic                  ch_ok, vld, tmo_hit, rsp_fire;
   logic [CH_W-1:0]       ch_sel;
   logic [DATA_W-1:0]     rsp;

   // Out-of-range channels are steered to entry 0 so the mux never reads
   // past the store; ch_ok suppresses anything derived from it.
   assign ch_ok   = ({1'b0, ch} < (CH_W+1)'(N_MEAS));
   assign ch_sel  = ch_ok ? ch : '0;
   assign vld     = ch_ok & meas_valid[ch_sel];
   assign tmo_hit = (cfg_timeout != '0) && (cnt == cfg_timeout);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (enable) state_nxt = LATCH;
         // A valid seen while latching is already after the request cycle,
         // so a FRESH read can complete straight from here.
         LATCH: if (!ch_ok || mode == LAST || vld) state_nxt = RESP;
                else                              state_nxt = WAIT;
         WAIT:  if (vld || tmo_hit) state_nxt = RESP;
         RESP:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Response word and counter update
   always_comb begin
      rsp      = '0;
      rsp_fire = 1'b0;
      cnt_nxt  = cnt;
      case (state)
         LATCH: begin
            cnt_nxt  = '0;
            rsp_fire = (state_nxt == RESP);
            if (!ch_ok)            rsp[ERR_BIT]      = 1'b1;
            else if (mode == LAST) rsp[MEAS_W-1:0]   = store[ch_sel];
            else                   rsp[MEAS_W-1:0]   = meas[ch_sel];
         end
         WAIT: begin
            cnt_nxt  = (&cnt) ? cnt : cnt + 1'b1;
            rsp_fire = vld | tmo_hit;
            // Fresh data wins over a coincident timeout.
            if (vld) begin
               rsp[MEAS_W-1:0] = meas[ch_sel];
            end else begin
               rsp[MEAS_W-1:0] = store[ch_sel];
               rsp[TMO_BIT]    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Request latch, counter and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch    <= '0;
         mode  <= LAST;
         cnt   <= '0;
         ready <= 1'b0;
         data  <= '0;
      end else begin
         if (state == IDLE && enable) begin
            ch   <= id[CH_W-1:0];
            mode <= mode_t'(id[ID_W-1]);
         end
         cnt   <= cnt_nxt;
         ready <= rsp_fire;
         if (rsp_fire) data <= rsp;
      end
   end

endmodule

// File: rtl/fproc_meas_fresh.sv
// fproc_meas_fresh: shared measurement store with N_CORES independent
// read ports (LAST = stored value, FRESH = wait for the next strobe).
//   clk, reset   : clock, async active-low reset
//   meas         : channel k result at [k*MEAS_W +: MEAS_W]
//   meas_valid   : per-channel one-cycle strobe
//   cfg_timeout  : FRESH wait limit in cycles, 0 = wait forever
//   core         : per-core request/response interfaces
module fproc_meas_fresh import fproc_meas_pkg::*; #(
   parameter int N_CORES   = 5,
   parameter int N_MEAS    = N_CORES,
   parameter int MEAS_W    = 1,
   parameter int TIMEOUT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_MEAS*MEAS_W-1:0]   meas,
   input  logic [N_MEAS-1:0]          meas_valid,
   input  logic [TIMEOUT_W-1:0]       cfg_timeout,
   fproc_iface.fproc                  core [N_CORES-1:0]
);
   logic [N_MEAS-1:0][MEAS_W-1:0] store;
   logic [N_MEAS-1:0][MEAS_W-1:0] meas_arr;

   assign meas_arr = meas;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store <= '0;
      end else begin
         for (int k = 0; k < N_MEAS; k++)
            if (meas_valid[k]) store[k] <= meas_arr[k];
      end
   end

   for (genvar g = 0; g < N_CORES; g++) begin : g_port
      fproc_meas_port #(
         .N_MEAS    (N_MEAS),
         .MEAS_W    (MEAS_W),
         .TIMEOUT_W (TIMEOUT_W)
      ) u_port (
         .clk         (clk),
         .reset       (reset),
         .enable      (core[g].enable),
         .id          (core[g].id),
         .store       (store),
         .meas        (meas_arr),
         .meas_valid  (meas_valid),
         .cfg_timeout (cfg_timeout),
         .ready       (core[g].ready),
         .data        (core[g].data)
      );
   end

endmodule

// File: tb/tb_fproc_meas_fresh.sv
module tb_fproc_meas_fresh;
   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       meas;
   logic [4:0]       meas_valid;
   logic [15:0]      cfg_timeout;
   logic [4:0]       en;
   logic [4:0][3:0]  req_id;
   logic [4:0]       rdy;
   logic [4:0][2:0]  dat;
   int               vectors = 0;
   int               errs    = 0;

   always #5 clk = ~clk;

   fproc_iface #(.N_MEAS(5), .MEAS_W(1)) core_if [4:0] ();

   for (genvar g = 0; g < 5; g++) begin : g_map
      assign core_if[g].enable = en[g];
      assign core_if[g].id     = req_id[g];
      assign rdy[g]            = core_if[g].ready;
      assign dat[g]            = core_if[g].data;
   end

   fproc_meas_fresh #(.N_CORES(5), .N_MEAS(5), .MEAS_W(1), .TIMEOUT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .meas        (meas),
      .meas_valid  (meas_valid),
      .cfg_timeout (cfg_timeout),
      .core        (core_if)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one-cycle store write on channel k
   task automatic put(input int k, input logic v);
      meas[k] = v;
      meas_valid[k] = 1'b1;
      cyc();
      meas_valid[k] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; en = '0; req_id = '0; meas = '0; meas_valid = '0; cfg_timeout = '0;
      cyc(); cyc();
      vectors++; if (rdy !== 5'b0) begin errs++; $display("FAIL reset_ready got %b exp 00000", rdy); end
      vectors++; if (dat !== 15'b0) begin errs++; $display("FAIL reset_data got %h exp 0", dat); end
      reset = 1'b1;
   endtask

   task automatic test_last();
      put(2, 1'b1);
      en[0] = 1'b1; req_id[0] = 4'd2; cyc(); en[0] = 1'b0;
      vectors++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL last_t1_ready got %b exp 0", rdy[0]); end
      cyc();
      vectors++; if (rdy[0] !== 1'b1) begin errs++; $display("FAIL last_t2_ready got %b exp 1", rdy[0]); end
      vectors++; if (dat[0] !== 3'b001) begin errs++; $display("FAIL last_t2_data got %b exp 001", dat[0]); end
      cyc();
      vectors++; if (rdy[0] !== 1'b0) begin errs++; $display("FAIL last_t3_ready got %b exp 0", rdy[0]); end
      vectors++; if (dat[0] !== 3'b001) begin errs++; $display("FAIL last_hold_data got %b exp 001", dat[0]); end
   endtask

   task automatic test_fresh();
      logic early = 1'b0;
      cfg_timeout = 16'd0;
      en[1] = 1'b1; req_id[1] = 4'b1011; cyc(); en[1] = 1'b0;
      repeat (9) begin if (rdy[1]) early = 1'b1; cyc(); end
      if (rdy[1]) early = 1'b1;
      vectors++; if (early !== 1'b0) begin errs++; $display("FAIL fresh_early got %b exp 0", early); end
      put(3, 1'b1);
      vectors++; if (rdy[1] !== 1'b1) begin errs++; $display("FAIL fresh_ready got %b exp 1", rdy[1]); end
      vectors++; if (dat[1] !== 3'b001) begin errs++; $display("FAIL fresh_data got %b exp 001", dat[1]); end
      cyc();
      vectors++; if (rdy[1] !== 1'b0) begin errs++; $display("FAIL fresh_pulse got %b exp 0", rdy[1]); end
   endtask

   task automatic test_timeout();
      logic early = 1'b0;
      cfg_timeout = 16'd5;
      put(4, 1'b1);
      en[2] = 1'b1; req_id[2] = 4'b1100; cyc(); en[2] = 1'b0;
      repeat (7) begin if (rdy[2]) early = 1'b1; cyc(); end
      vectors++; if (early !== 1'b0) begin errs++; $display("FAIL tmo_early got %b exp 0", early); end
      vectors++; if (rdy[2] !== 1'b1) begin errs++; $display("FAIL tmo_ready got %b exp 1", rdy[2]); end
      vectors++; if (dat[2] !== 3'b011) begin errs++; $display("FAIL tmo_data got %b exp 011", dat[2]); end
      cyc();
      en[2] = 1'b1; cyc(); en[2] = 1'b0;
      repeat (6) cyc();
      put(4, 1'b0);
      vectors++; if (rdy[2] !== 1'b1) begin errs++; $display("FAIL tmo_race_ready got %b exp 1", rdy[2]); end
      vectors++; if (dat[2] !== 3'b000) begin errs++; $display("FAIL tmo_race_data got %b exp 000", dat[2]); end
      cfg_timeout = 16'd0;
      cyc();
   endtask

   task automatic test_stale();
      logic early = 1'b0;
      meas[0] = 1'b0; meas_valid[0] = 1'b1;
      en[3] = 1'b1; req_id[3] = 4'b1000; cyc();
      meas_valid[0] = 1'b0; en[3] = 1'b0;
      repeat (5) begin if (rdy[3]) early = 1'b1; cyc(); end
      vectors++; if (early !== 1'b0) begin errs++; $display("FAIL stale_early got %b exp 0", early); end
      put(0, 1'b1);
      vectors++; if (rdy[3] !== 1'b1) begin errs++; $display("FAIL stale_ready got %b exp 1", rdy[3]); end
      vectors++; if (dat[3] !== 3'b001) begin errs++; $display("FAIL stale_data got %b exp 001", dat[3]); end
      cyc();
   endtask

   task automatic test_multi();
      logic extra = 1'b0;
      en = 5'b11111;
      req_id[0] = 4'b1001; req_id[1] = 4'b1001; req_id[2] = 4'b1001;
      req_id[3] = 4'b0001; req_id[4] = 4'd5;
      cyc(); en = '0;
      cyc();
      vectors++; if (rdy !== 5'b11000) begin errs++; $display("FAIL multi_t2_ready got %b exp 11000", rdy); end
      vectors++; if (dat[3] !== 3'b000) begin errs++; $display("FAIL multi_last_data got %b exp 000", dat[3]); end
      vectors++; if (dat[4] !== 3'b100) begin errs++; $display("FAIL multi_err_data got %b exp 100", dat[4]); end
      en[0] = 1'b1; req_id[0] = 4'd2; cyc(); en[0] = 1'b0;
      vectors++; if (rdy !== 5'b00000) begin errs++; $display("FAIL multi_busy_ready got %b exp 00000", rdy); end
      cyc();
      put(1, 1'b1);
      vectors++; if (rdy !== 5'b00111) begin errs++; $display("FAIL multi_release got %b exp 00111", rdy); end
      vectors++; if ({dat[2], dat[1], dat[0]} !== 9'b001001001) begin
         errs++; $display("FAIL multi_release_data got %b exp 001001001", {dat[2], dat[1], dat[0]}); end
      repeat (4) begin cyc(); if (rdy !== 5'b0) extra = 1'b1; end
      vectors++; if (extra !== 1'b0) begin errs++; $display("FAIL multi_no_queue got %b exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      logic spur = 1'b0;
      en[1] = 1'b1; req_id[1] = 4'b1010; cyc(); en[1] = 1'b0;
      repeat (3) cyc();
      #2 reset = 1'b0;
      #1;
      vectors++; if (rdy !== 5'b0) begin errs++; $display("FAIL rmid_ready got %b exp 00000", rdy); end
      vectors++; if (dat !== 15'b0) begin errs++; $display("FAIL rmid_data got %h exp 0", dat); end
      cyc();
      reset = 1'b1;
      put(2, 1'b1);
      if (rdy !== 5'b0) spur = 1'b1;
      en[0] = 1'b1; req_id[0] = 4'd2; cyc(); en[0] = 1'b0;
      if (rdy !== 5'b0) spur = 1'b1;
      vectors++; if (spur !== 1'b0) begin errs++; $display("FAIL rmid_spurious got %b exp 0", spur); end
      cyc();
      vectors++; if (rdy !== 5'b00001) begin errs++; $display("FAIL rmid_after_ready got %b exp 00001", rdy); end
      vectors++; if (dat[0] !== 3'b001) begin errs++; $display("FAIL rmid_after_data got %b exp 001", dat[0]); end
   endtask

   initial begin
      test_reset();
      test_last();
      test_fresh();
      test_timeout();
      test_stale();
      test_multi();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
